// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron driver: FSM encoding, class and
// histogram widths, reference 5x5 patterns and the saturating-count helper.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CAPTURE,
        ABORT,
        PUSH,
        GAP,
        FIN
    } drv_state_t;

    localparam int CLASS_W     = 2;
    localparam int NUM_CLASSES = 1 << CLASS_W;
    localparam int HIST_W      = 8;

    localparam logic [24:0] PAT_CROSS  = {1'b1, 24'h15_11_51};
    localparam logic [24:0] PAT_CIRCLE = {1'b0, 24'h45_45_44};

    function automatic logic [HIST_W-1:0] sat_inc(input logic [HIST_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/perceptron_drv_hist.sv
// Per-class result histogram: one saturating 8-bit counter per perceptron class,
// cleared at the start of each run.
module perceptron_drv_hist
    import perceptron_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clr,
    input  logic                          i_inc,
    input  logic [CLASS_W-1:0]            i_sel,
    output logic [NUM_CLASSES*HIST_W-1:0] o_hist
);

    logic [HIST_W-1:0] r_cnt [NUM_CLASSES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
        end else if (i_clr) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
        end else if (i_inc) begin
            r_cnt[i_sel] <= sat_inc(r_cnt[i_sel]);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) o_hist[c*HIST_W +: HIST_W] = r_cnt[c];
    end

endmodule

// File: rtl/perceptron_driver.sv
// Initiator for the perceptron en/ready handshake: replays host-loaded patterns,
// captures class/acc after a minimum hold, and streams results with valid/ready.
module perceptron_driver
    import perceptron_pkg::*;
#(
    parameter int WIDTH    = 25,
    parameter int DEPTH    = 4,
    parameter int ACC_W    = $clog2(WIDTH),
    parameter int MIN_HOLD = 6,
    parameter int TIMEOUT  = 4 * WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_we,
    input  logic [$clog2(DEPTH)-1:0]      ld_addr,
    input  logic [WIDTH-1:0]              ld_data,
    input  logic                          start,
    input  logic [$clog2(DEPTH):0]        num,
    output logic [WIDTH-1:0]              p_in,
    output logic                          p_en,
    input  logic                          p_ready,
    input  logic [CLASS_W-1:0]            p_out,
    input  logic [ACC_W-1:0]              p_acc,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(DEPTH)-1:0]      res_idx,
    output logic [CLASS_W-1:0]            res_class,
    output logic [ACC_W-1:0]              res_acc,
    output logic                          res_tmo,
    output logic [NUM_CLASSES*HIST_W-1:0] hist,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int NUM_W  = IDX_W + 1;
    localparam int HOLD_W = $clog2(TIMEOUT + 1);

    drv_state_t         r_state, w_next;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [NUM_W-1:0]   r_idx, r_num, w_num_lim;
    logic [HOLD_W-1:0]  r_hold;
    logic [WIDTH-1:0]   r_p_in;
    logic               r_p_en, r_res_valid, r_res_tmo;
    logic [IDX_W-1:0]   r_res_idx;
    logic [CLASS_W-1:0] r_res_class;
    logic [ACC_W-1:0]   r_res_acc;
    logic               w_busy, w_capture, w_timeout, w_last;

    assign w_busy    = (r_state != IDLE) && (r_state != FIN);
    assign w_capture = p_ready && (r_hold >= HOLD_W'(MIN_HOLD));
    assign w_timeout = (r_hold == HOLD_W'(TIMEOUT - 1));
    assign w_last    = ((r_idx + 1'b1) == r_num);
    assign w_num_lim = (num > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : num;

    // NOTE: the pattern memory has no reset; the host always loads it before use,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (ld_we && !w_busy) r_mem[ld_addr] <= ld_data;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:           if (start) w_next = (num == '0) ? FIN : DRIVE;
            DRIVE:          w_next = WAIT;
            WAIT:           if (w_capture) w_next = CAPTURE;
                            else if (w_timeout) w_next = ABORT;
            CAPTURE, ABORT: w_next = PUSH;
            PUSH:           if (res_ready) w_next = GAP;
            GAP:            w_next = w_last ? FIN : DRIVE;
            FIN:            w_next = IDLE;
            default:        w_next = IDLE;
        endcase
    end

    // p_out/p_acc are sampled on the WAIT exit edge, while the perceptron still sees en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_num       <= '0;
            r_hold      <= '0;
            r_p_in      <= '0;
            r_p_en      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_tmo   <= 1'b0;
            r_res_idx   <= '0;
            r_res_class <= '0;
            r_res_acc   <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (start) begin
                    r_idx <= '0;
                    r_num <= w_num_lim;
                end
                DRIVE: begin
                    r_p_in <= r_mem[r_idx[IDX_W-1:0]];
                    r_p_en <= 1'b1;
                    r_hold <= '0;
                end
                WAIT: begin
                    r_hold <= r_hold + 1'b1;
                    if (w_capture || w_timeout) begin
                        r_p_en      <= 1'b0;
                        r_res_idx   <= r_idx[IDX_W-1:0];
                        r_res_tmo   <= !w_capture;
                        r_res_class <= w_capture ? p_out : '0;
                        r_res_acc   <= w_capture ? p_acc : '0;
                    end
                end
                CAPTURE, ABORT: r_res_valid <= 1'b1;
                PUSH:           if (res_ready) r_res_valid <= 1'b0;
                GAP:            r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    perceptron_drv_hist u_hist (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  ((r_state == IDLE) && start),
        .i_inc  (r_state == CAPTURE),
        .i_sel  (r_res_class),
        .o_hist (hist)
    );

    assign p_in      = r_p_in;
    assign p_en      = r_p_en;
    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_class = r_res_class;
    assign res_acc   = r_res_acc;
    assign res_tmo   = r_res_tmo;
    assign busy      = w_busy;
    assign done      = (r_state == FIN);

endmodule

// File: tb/tb_perceptron_driver.sv
// Self-checking bench for perceptron_driver: a behavioural perceptron with
// selectable ready behaviour, random patterns and backpressure, and a scoreboard.
module tb_perceptron_driver;
    import perceptron_pkg::*;

    localparam int WIDTH    = 25;
    localparam int DEPTH    = 4;
    localparam int ACC_W    = 5;
    localparam int MIN_HOLD = 6;
    localparam int TIMEOUT  = 100;

    logic              clk = 1'b0;
    logic              rst_n, ld_we, start, p_en, p_ready, res_valid, res_ready, res_tmo, busy, done;
    logic [1:0]        ld_addr, res_idx, p_out, res_class;
    logic [2:0]        num;
    logic [WIDTH-1:0]  ld_data, p_in;
    logic [ACC_W-1:0]  p_acc, res_acc;
    logic [31:0]       hist;

    perceptron_driver #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(ACC_W), .MIN_HOLD(MIN_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .num(num), .p_in(p_in), .p_en(p_en), .p_ready(p_ready),
        .p_out(p_out), .p_acc(p_acc), .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_class(res_class), .res_acc(res_acc), .res_tmo(res_tmo),
        .hist(hist), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] idx; logic [1:0] cls; logic [4:0] acc; logic tmo; } res_t;
    typedef struct { logic [WIDTH-1:0] pat; int len; } en_t;

    int               n_cmp = 0, n_bad = 0;
    logic [WIDTH-1:0] shadow [DEPTH];
    res_t             exp_res[$];
    en_t              exp_en[$];
    int               mode = 0, lat = 0, stall_len = 0;
    bit               ignore_en = 1'b0;
    int               en_rises = 0, done_cnt = 0, res_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural perceptron classification: the two reference images, else popcount.
    function automatic void perc(input logic [WIDTH-1:0] p, output logic [1:0] c, output logic [4:0] a);
        if (p == PAT_CROSS) begin
            c = 2'd3; a = 5'd11;
        end else if (p == PAT_CIRCLE) begin
            c = 2'd2; a = 5'd4;
        end else begin
            a = 5'($countones(p));
            c = a[4:3];
        end
    endfunction

    // Perceptron model (mode 0: ready after lat en-cycles, 1: ready stuck high, 2: never)
    // plus checking of each en burst: length, presented pattern and stability.
    initial begin
        int               en_cnt;
        logic             prev_en, rdy;
        logic [WIDTH-1:0] rise_pin;
        en_t              e;
        en_cnt = 0; prev_en = 1'b0; rise_pin = '0;
        p_ready = 1'b0; p_out = '0; p_acc = '0;
        forever begin
            @(posedge clk); #1;
            if (p_en === 1'b1) begin
                if (!prev_en) begin
                    en_rises++;
                    rise_pin = p_in;
                end
                en_cnt++;
            end else if (prev_en) begin
                if (!ignore_en) begin
                    if (exp_en.size() == 0) begin
                        check("unexpected_en_burst", 64'(en_cnt), 64'(0));
                    end else begin
                        e = exp_en.pop_front();
                        check("en_len", 64'(en_cnt), 64'(e.len));
                        check("p_in_pattern", 64'(rise_pin), 64'(e.pat));
                        check("p_in_held", 64'(p_in), 64'(rise_pin));
                    end
                end
                en_cnt = 0;
            end
            prev_en = (p_en === 1'b1);
            case (mode)
                1:       rdy = 1'b1;
                2:       rdy = 1'b0;
                default: rdy = prev_en && (en_cnt - 1 >= lat);
            endcase
            if (rdy && prev_en) perc(p_in, p_out, p_acc);
            else {p_out, p_acc} = 7'($urandom);
            p_ready = rdy;
        end
    end

    // Consumer: holds res_ready low for stall_len cycles of each result.
    initial begin
        int stall;
        stall = 0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) begin
                if (stall < stall_len) begin
                    res_ready = 1'b0;
                    stall++;
                end else begin
                    res_ready = 1'b1;
                end
            end else begin
                stall = 0;
                res_ready = (stall_len == 0);
            end
        end
    end

    // Result scoreboard, stability while stalled, p_en quiet during push, done counting.
    initial begin
        res_t cur, prev, e;
        logic prev_pend;
        prev_pend = 1'b0;
        prev = '{default: '0};
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            cur = '{idx: res_idx, cls: res_class, acc: res_acc, tmo: res_tmo};
            if (res_valid === 1'b1) begin
                check("p_en_low_while_valid", 64'(p_en), 64'(0));
                if (prev_pend) check("res_stable", 64'({cur.idx, cur.cls, cur.acc, cur.tmo}),
                                     64'({prev.idx, prev.cls, prev.acc, prev.tmo}));
                if (res_ready === 1'b1) begin
                    res_cnt++;
                    if (exp_res.size() == 0) begin
                        check("unexpected_result", 64'(cur.idx), 64'(0));
                    end else begin
                        e = exp_res.pop_front();
                        check("res_idx", 64'(cur.idx), 64'(e.idx));
                        check("res_class", 64'(cur.cls), 64'(e.cls));
                        check("res_acc", 64'(cur.acc), 64'(e.acc));
                        check("res_tmo", 64'(cur.tmo), 64'(e.tmo));
                    end
                end
            end
            prev_pend = (res_valid === 1'b1) && (res_ready !== 1'b1);
            prev = cur;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input int addr, input logic [WIDTH-1:0] data);
        @(posedge clk); #1;
        ld_we = 1'b1; ld_addr = 2'(addr); ld_data = data;
        @(posedge clk); #1;
        ld_we = 1'b0;
        shadow[addr] = data;
    endtask

    // Builds the expected results, en bursts and histogram for a run from the shadow memory.
    task automatic prep(input int n, input int md, input int l, input int stl, output logic [31:0] h_exp);
        int   cnt [4];
        res_t r;
        en_t  e;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        mode = md; lat = l; stall_len = stl;
        for (int i = 0; i < n; i++) begin
            r.idx = 2'(i);
            e.pat = shadow[i];
            if (md == 2) begin
                r.cls = '0; r.acc = '0; r.tmo = 1'b1;
                e.len = TIMEOUT;
            end else begin
                perc(shadow[i], r.cls, r.acc);
                r.tmo = 1'b0;
                e.len = ((md == 1) ? MIN_HOLD : ((l > MIN_HOLD) ? l : MIN_HOLD)) + 1;
                if (cnt[r.cls] < 255) cnt[r.cls]++;
            end
            exp_res.push_back(r);
            exp_en.push_back(e);
        end
        h_exp = {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
    endtask

    task automatic go(input int n, input bit disturb, input logic [31:0] h_exp);
        int rises0, cyc;
        rises0 = en_rises; done_cnt = 0; res_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; num = 3'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) check("num0_done_next_cycle", 64'(done), 64'(1));
        if (disturb) begin
            repeat (3) @(posedge clk);
            #1;
            ld_we = 1'b1; ld_addr = 2'd0; ld_data = ~shadow[0];
            start = 1'b1; num = 3'd1;
            @(posedge clk); #1;
            ld_we = 1'b0; start = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_within_budget", 64'(cyc < 5000), 64'(1));
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("result_count", 64'(res_cnt), 64'(n));
        check("en_bursts", 64'(en_rises - rises0), 64'(n));
        check("results_left", 64'(exp_res.size() + exp_en.size()), 64'(0));
        check("hist", 64'(hist), 64'(h_exp));
        check("busy_after_run", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [31:0] h_exp;
        int          n, md, cyc;
        rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; num = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_p_en", 64'(p_en), 64'(0));
        check("reset_p_in", 64'(p_in), 64'(0));
        check("reset_res", 64'({res_valid, res_idx, res_class, res_acc, res_tmo}), 64'(0));
        check("reset_busy_done", 64'({busy, done}), 64'(0));
        check("reset_hist", 64'(hist), 64'(0));
        rst_n = 1'b1;

        // Reference images, free-flowing consumer.
        load(0, PAT_CIRCLE); load(1, PAT_CROSS); load(2, PAT_CROSS); load(3, PAT_CIRCLE);
        prep(4, 0, int'($urandom_range(0, 12)), 0, h_exp);
        check("ref_hist_c3c2", 64'(h_exp), 64'(32'h02_02_00_00));
        go(4, 1'b0, h_exp);

        // 20-cycle backpressure with a write and start attempted while busy, then a rerun
        // that would expose any memory corruption.
        prep(4, 0, int'($urandom_range(0, 12)), 20, h_exp);
        go(4, 1'b1, h_exp);
        prep(4, 0, 3, 0, h_exp);
        go(4, 1'b0, h_exp);

        // Stale ready stuck high, then a dead perceptron that times out every pattern.
        prep(4, 1, 0, 0, h_exp);
        go(4, 1'b0, h_exp);
        prep(3, 2, 0, 0, h_exp);
        go(3, 1'b0, h_exp);

        // Empty run.
        prep(0, 0, 0, 0, h_exp);
        go(0, 1'b0, 32'h0);

        // Random patterns, lengths, perceptron behaviour and backpressure.
        for (int k = 0; k < 8; k++) begin
            for (int a = 0; a < DEPTH; a++) load(a, 25'($urandom));
            n  = int'($urandom_range(1, 4));
            md = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
            prep(n, md, int'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0, h_exp);
            go(n, 1'($urandom_range(0, 1)), h_exp);
        end

        // Asynchronous reset while pattern 2 is being driven.
        load(0, PAT_CROSS); load(1, PAT_CIRCLE); load(2, PAT_CROSS); load(3, PAT_CROSS);
        prep(4, 0, 10, 0, h_exp);
        res_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; num = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(res_cnt == 2 && p_en === 1'b1) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_idx2_wait", 64'(cyc < 2000), 64'(1));
        repeat (3) @(negedge clk);
        ignore_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_p_en", 64'(p_en), 64'(0));
        check("async_rst_res_valid", 64'(res_valid), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_hist", 64'(hist), 64'(0));
        exp_res.delete();
        exp_en.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ignore_en = 1'b0;
        load(0, PAT_CIRCLE); load(1, PAT_CROSS); load(2, PAT_CIRCLE); load(3, PAT_CROSS);
        prep(4, 0, int'($urandom_range(0, 12)), 2, h_exp);
        go(4, 1'b0, h_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
